// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares the core's single memory bus port between
// instruction fetch (if_*), data load/store (d_*) and the page-table walker
// (ptw_*). Only one transaction is outstanding at a time. The arbiter owns the
// bus from grant until the response returns, then routes that response to the
// requester that owned the transaction.
//
// Ports:
//   clk, rst_n                  core clock, synchronous active-low reset
//   if_req_*  / if_rsp_valid    fetch request (read only) and response pulse
//   ptw_req_* / ptw_rsp_valid   walker request (read only) and response pulse
//   d_req_*   / d_rsp_valid     data request (read or write) and response pulse
//   rsp_rdata, rsp_err          shared response payload, valid with any *_rsp_valid
//   bus_req_* / bus_addr/wen/wdata/wstrb   registered bus request
//   bus_rsp_valid, bus_rdata    bus response (one per accepted request)
//
// The *_req_ready outputs are combinational from the request valids (IDLE only);
// every other output is registered.
module core_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMO_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        ptw_req_valid,
  output logic        ptw_req_ready,
  input  logic [31:0] ptw_req_addr,
  output logic        ptw_rsp_valid,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_wen,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;
  typedef enum logic [1:0] {OWN_IF = 2'd0, OWN_D = 2'd1, OWN_PTW = 2'd2} owner_t;

  state_t           state, state_d;
  owner_t           owner;
  logic             last_d;      // 1: data was the last fetch/data grant
  logic [TMO_W-1:0] tmo_cnt;
  logic             gnt_if, gnt_d, gnt_ptw;
  logic             rsp_fire, tmo_fire;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state, grant selection and response/timeout detection.
  always_comb begin
    state_d  = state;
    gnt_if   = 1'b0;
    gnt_d    = 1'b0;
    gnt_ptw  = 1'b0;
    rsp_fire = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        // Walker has fixed priority; fetch/data tie goes to the one not granted last.
        if (ptw_req_valid) begin
          gnt_ptw = 1'b1;
        end else if (if_req_valid && d_req_valid) begin
          gnt_if = last_d;
          gnt_d  = !last_d;
        end else begin
          gnt_if = if_req_valid;
          gnt_d  = d_req_valid;
        end
        if (gnt_ptw || gnt_if || gnt_d) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        // A real response in the timeout cycle takes precedence.
        if (bus_rsp_valid) rsp_fire = 1'b1;
        else if (TMO_EN && (tmo_cnt == TMO_LAST)) tmo_fire = 1'b1;
        if (rsp_fire || tmo_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_req_ready  = gnt_if;
  assign d_req_ready   = gnt_d;
  assign ptw_req_ready = gnt_ptw;

  // Bus payload, ownership, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner         <= OWN_IF;
      last_d        <= 1'b1;
      tmo_cnt       <= '0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_wen       <= 1'b0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
      if_rsp_valid  <= 1'b0;
      d_rsp_valid   <= 1'b0;
      ptw_rsp_valid <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      if_rsp_valid  <= 1'b0;
      d_rsp_valid   <= 1'b0;
      ptw_rsp_valid <= 1'b0;

      if (gnt_ptw) begin
        bus_req_valid <= 1'b1;
        bus_addr      <= ptw_req_addr;
        bus_wen       <= 1'b0;
        bus_wdata     <= '0;
        bus_wstrb     <= 4'hF;
        owner         <= OWN_PTW;
      end else if (gnt_if) begin
        bus_req_valid <= 1'b1;
        bus_addr      <= if_req_addr;
        bus_wen       <= 1'b0;
        bus_wdata     <= '0;
        bus_wstrb     <= 4'hF;
        owner         <= OWN_IF;
        last_d        <= 1'b0;
      end else if (gnt_d) begin
        bus_req_valid <= 1'b1;
        bus_addr      <= d_req_addr;
        bus_wen       <= d_req_wen;
        bus_wdata     <= d_req_wdata;
        bus_wstrb     <= d_req_wstrb;
        owner         <= OWN_D;
        last_d        <= 1'b1;
      end

      if ((state == ST_REQ) && bus_req_ready) begin
        bus_req_valid <= 1'b0;
        tmo_cnt       <= '0;
      end

      if ((state == ST_RSP) && !rsp_fire && !tmo_fire) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (rsp_fire || tmo_fire) begin
        rsp_rdata <= rsp_fire ? bus_rdata : 32'h0;
        rsp_err   <= tmo_fire;
        case (owner)
          OWN_IF:  if_rsp_valid  <= 1'b1;
          OWN_D:   d_rsp_valid   <= 1'b1;
          default: ptw_rsp_valid <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed requests push their expected
// grant, bus payload and response; independent monitors compare on each DUT event.
module tb_core_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk, rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr;
  logic        ptw_req_valid, ptw_req_ready, ptw_rsp_valid;
  logic [31:0] ptw_req_addr;
  logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req_valid, bus_req_ready, bus_wen, bus_rsp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rsp_cyc = -1;
  int grant_cyc[3];

  int          exp_grant[$];
  bus_t        exp_bus[$];
  rsp_t        exp_rsp[$];
  logic [31:0] rdq[$];

  bit mute = 0;
  bit stale_req = 0;
  int ready_delay = 0;

  core_mem_arbiter #(.TIMEOUT_CYCLES(8), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
    .ptw_req_addr(ptw_req_addr), .ptw_rsp_valid(ptw_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr), .d_req_wen(d_req_wen),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: ready after ready_delay wait cycles, response the cycle after accept.
  initial begin
    bit acc;
    int req_wait;
    acc = 0; req_wait = 0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      bus_rdata     = '0;
      if (acc) begin
        acc = 0;
        if (!mute) begin
          bus_rsp_valid = 1'b1;
          bus_rdata     = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
        end
      end
      if (stale_req) begin
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hBAD0BAD0;
        stale_req     = 0;
      end
      bus_req_ready = 1'b0;
      if (bus_req_valid && rst_n) begin
        if (req_wait >= ready_delay) begin
          bus_req_ready = 1'b1;
          acc = 1;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end
    end
  end

  // Grant monitor: one ready at a time, in the expected order.
  initial forever begin
    int n, w;
    @(negedge clk);
    n = int'(if_req_ready) + int'(d_req_ready) + int'(ptw_req_ready);
    if (n > 1) begin
      total++; bad++;
      $display("FAIL grant_onehot readies=%0d want<=1", n);
    end else if (n == 1) begin
      w = if_req_ready ? 0 : (d_req_ready ? 1 : 2);
      grant_cyc[w] = cyc;
      total++;
      if (exp_grant.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected who=%0d want=none", w);
      end else begin
        int e;
        e = exp_grant.pop_front();
        if (e != w) begin
          bad++;
          $display("FAIL grant_order got=%0d want=%0d", w, e);
        end
      end
    end
  end

  // Bus monitor: payload matches and stays stable; no grants while a request is pending.
  initial forever begin
    bus_t got;
    @(negedge clk);
    if (bus_req_valid) begin
      got = '{bus_addr, bus_wen, bus_wdata, bus_wstrb};
      total++;
      if (exp_bus.size() == 0) begin
        bad++;
        $display("FAIL bus_unexpected got=%h want=none", got);
      end else if (got !== exp_bus[0]) begin
        bad++;
        $display("FAIL bus_payload got=%h want=%h", got, exp_bus[0]);
      end
      total++;
      if (if_req_ready || d_req_ready || ptw_req_ready) begin
        bad++;
        $display("FAIL ready_while_busy got=%b%b%b want=000", if_req_ready, d_req_ready, ptw_req_ready);
      end
      if (bus_req_ready && exp_bus.size() > 0) void'(exp_bus.pop_front());
    end
  end

  // Response monitor.
  initial forever begin
    int n;
    rsp_t got, e;
    @(negedge clk);
    n = int'(if_rsp_valid) + int'(d_rsp_valid) + int'(ptw_rsp_valid);
    if (n > 1) begin
      total++; bad++;
      $display("FAIL rsp_onehot pulses=%0d want<=1", n);
    end else if (n == 1) begin
      got.who   = if_rsp_valid ? 2'd0 : (d_rsp_valid ? 2'd1 : 2'd2);
      got.rdata = rsp_rdata;
      got.err   = rsp_err;
      last_rsp_cyc = cyc;
      total++;
      if (exp_rsp.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got=%h want=none", got);
      end else begin
        e = exp_rsp.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL rsp_data got who=%0d rdata=%h err=%b want who=%0d rdata=%h err=%b",
                   got.who, got.rdata, got.err, e.who, e.rdata, e.err);
        end
      end
    end
  end

  task automatic expect_txn(input int who, input logic [31:0] a, input logic wen,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] rd, input bit to);
    rsp_t r;
    exp_grant.push_back(who);
    exp_bus.push_back('{a, wen, wd, ws});
    if (!to) rdq.push_back(rd);
    r.who = 2'(who); r.rdata = to ? 32'h0 : rd; r.err = to;
    exp_rsp.push_back(r);
  endtask

  // Raise a request now and hold it until accepted (caller is at posedge+1).
  task automatic req(input int who, input logic [31:0] a, input logic wen,
                     input logic [31:0] wd, input logic [3:0] ws);
    bit got;
    got = 0;
    case (who)
      0: begin if_req_valid = 1'b1; if_req_addr = a; end
      1: begin d_req_valid = 1'b1; d_req_addr = a; d_req_wen = wen;
               d_req_wdata = wd; d_req_wstrb = ws; end
      default: begin ptw_req_valid = 1'b1; ptw_req_addr = a; end
    endcase
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      case (who)
        0: got = if_req_ready;
        1: got = d_req_ready;
        default: got = ptw_req_ready;
      endcase
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL req_accept who=%0d got=0 want=1", who);
    end
    @(posedge clk); #1;
    case (who)
      0: if_req_valid = 1'b0;
      1: d_req_valid = 1'b0;
      default: ptw_req_valid = 1'b0;
    endcase
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_grant.size() + exp_bus.size() + exp_rsp.size()) > 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (i >= 300) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", exp_grant.size() + exp_bus.size() + exp_rsp.size());
      exp_grant.delete(); exp_bus.delete(); exp_rsp.delete(); rdq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [108:0] snap;
    snap = {if_req_ready, ptw_req_ready, d_req_ready, if_rsp_valid, ptw_rsp_valid,
            d_rsp_valid, rsp_rdata, rsp_err, bus_req_valid, bus_addr, bus_wen,
            bus_wdata, bus_wstrb};
    total++;
    if (snap !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", tag, snap);
    end
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = '0;
    ptw_req_valid = 0; ptw_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_wen = 0; d_req_wdata = '0; d_req_wstrb = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All three at once: PTW, then fetch (last_grant resets to data), then data.
    expect_txn(2, 32'h0000_3000, 1'b0, 32'h0, 4'hF, 32'h3333_0000, 0);
    expect_txn(0, 32'h0000_1004, 1'b0, 32'h0, 4'hF, 32'h1111_0000, 0);
    expect_txn(1, 32'h0000_2008, 1'b0, 32'h0, 4'hF, 32'h2222_0000, 0);
    fork
      req(2, 32'h0000_3000, 1'b0, 32'h0, 4'hF);
      req(0, 32'h0000_1004, 1'b0, 32'h0, 4'hF);
      req(1, 32'h0000_2008, 1'b0, 32'h0, 4'hF);
    join
    drain();

    // Fetch and data continuously valid: F,D,F,D.
    expect_txn(0, 32'h0000_1100, 1'b0, 32'h0, 4'hF, 32'hA000_0001, 0);
    expect_txn(1, 32'h0000_2100, 1'b0, 32'h0, 4'hF, 32'hB000_0001, 0);
    expect_txn(0, 32'h0000_1104, 1'b0, 32'h0, 4'hF, 32'hA000_0002, 0);
    expect_txn(1, 32'h0000_2104, 1'b0, 32'h0, 4'hF, 32'hB000_0002, 0);
    fork
      begin req(0, 32'h0000_1100, 1'b0, 32'h0, 4'hF); req(0, 32'h0000_1104, 1'b0, 32'h0, 4'hF); end
      begin req(1, 32'h0000_2100, 1'b0, 32'h0, 4'hF); req(1, 32'h0000_2104, 1'b0, 32'h0, 4'hF); end
    join
    drain();

    // Single fetch, minimum latency: grant at cycle 0, response at cycle 3.
    g = cyc;
    expect_txn(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 0);
    req(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
    drain();
    total++;
    if (grant_cyc[0] != g) begin
      bad++; $display("FAIL fetch_grant_cycle got=%0d want=%0d", grant_cyc[0], g);
    end
    total++;
    if (last_rsp_cyc != g + 3) begin
      bad++; $display("FAIL fetch_rsp_cycle got=%0d want=%0d", last_rsp_cyc, g + 3);
    end

    // Store with partial strobes.
    expect_txn(1, 32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011, 32'h0, 0);
    req(1, 32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011);
    drain();

    // Bus stalls 5 cycles; a data request arriving meanwhile must wait.
    ready_delay = 5;
    expect_txn(0, 32'h0000_2000, 1'b0, 32'h0, 4'hF, 32'h5A5A_5A5A, 0);
    expect_txn(1, 32'h0000_2004, 1'b0, 32'h0, 4'hF, 32'h6B6B_6B6B, 0);
    fork
      req(0, 32'h0000_2000, 1'b0, 32'h0, 4'hF);
      begin repeat (2) @(posedge clk); #1; req(1, 32'h0000_2004, 1'b0, 32'h0, 4'hF); end
    join
    drain();
    ready_delay = 0;

    // Bus never responds: error response after the watchdog expires.
    mute = 1;
    g = cyc;
    expect_txn(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'h0, 1);
    req(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
    drain();
    mute = 0;
    total++;
    if (last_rsp_cyc != g + 10) begin
      bad++; $display("FAIL timeout_cycle got=%0d want=%0d", last_rsp_cyc, g + 10);
    end

    // Stale bus response in IDLE, then a normal request.
    stale_req = 1;
    repeat (4) @(posedge clk); #1;
    expect_txn(1, 32'h0000_0300, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 0);
    req(1, 32'h0000_0300, 1'b0, 32'h0, 4'hF);
    drain();

    // Reset while waiting in RSP: no response afterwards.
    mute = 1;
    exp_grant.push_back(0);
    exp_bus.push_back('{32'h0000_4000, 1'b0, 32'h0, 4'hF});
    req(0, 32'h0000_4000, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 50 && exp_bus.size() > 0; i++) @(negedge clk);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_rsp");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mute = 0;
    exp_grant.delete(); exp_bus.delete();
    repeat (15) @(posedge clk); #1;

    // After reset the fetch/data tie goes to fetch again.
    expect_txn(0, 32'h0000_5000, 1'b0, 32'h0, 4'hF, 32'h0000_0077, 0);
    expect_txn(1, 32'h0000_5004, 1'b0, 32'h0, 4'hF, 32'h0000_0088, 0);
    fork
      req(0, 32'h0000_5000, 1'b0, 32'h0, 4'hF);
      req(1, 32'h0000_5004, 1'b0, 32'h0, 4'hF);
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Arbitrates the core's single memory bus port between three requesters:
  - instruction fetch, from core_s1
  - data load/store, from core_s2
  - page-table walker reads, from core_mmu
- Exactly one transaction is outstanding at a time. The arbiter owns the bus from grant until the response returns, then routes that response back to the owning requester.
- Sits inside core_top between the stage/MMU instances and the external memory interface.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in RSP before an error response is forced; 0 disables the watchdog.
- TMO_W, 16: watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**TMO_W.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch address (word aligned)
- if_rsp_valid  out  1  fetch response valid (1-cycle pulse)
- ptw_req_valid  in  1  walker request valid
- ptw_req_ready  out  1  walker request accepted
- ptw_req_addr  in  32  PTE physical address
- ptw_rsp_valid  out  1  walker response pulse
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_addr  in  32  data address
- d_req_wen  in  1  1 = store
- d_req_wdata  in  32  store data
- d_req_wstrb  in  4  store byte enables
- d_rsp_valid  out  1  data response pulse
- rsp_rdata  out  32  read data, shared by all requesters, valid with any rsp_valid
- rsp_err  out  1  response error (watchdog timeout), valid with any rsp_valid
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  32  bus address
- bus_wen  out  1  bus write
- bus_wdata  out  32  bus write data
- bus_wstrb  out  4  bus byte enables
- bus_rsp_valid  in  1  bus response valid (one per accepted request, reads and writes)
- bus_rdata  in  32  bus read data

Behaviour:
- Requester rules:
  - A requester holds valid and its payload stable until it sees ready.
  - ready is asserted only in IDLE, only to the winner, and combinationally from the valids.
- FSM states:
  - IDLE, REQ, RSP.
- IDLE:
  - If any valid is asserted, pick a winner and assert its ready. Register the payload into the bus output registers and the owner register, then go to REQ.
  - Fetch and PTW drive wen=0, wdata=0, wstrb=4'hF.
- Arbitration:
  - PTW has fixed highest priority.
  - Fetch and data share round-robin via a last_grant bit; the one not granted last wins a tie.
  - last_grant is updated only on fetch/data grants; a PTW grant leaves it unchanged.
  - Reset value of last_grant is "data", so fetch wins the first tie.
- REQ:
  - bus_req_valid=1 with the registered payload.
  - On bus_req_ready, go to RSP and clear the watchdog counter.
  - Payload stays stable while waiting for bus_req_ready.
- RSP:
  - bus_req_valid=0.
  - On bus_rsp_valid, pulse the owner's *_rsp_valid for 1 cycle, with rsp_rdata=bus_rdata and rsp_err=0, and go to IDLE.
  - rsp outputs are registered: the pulse appears the cycle after bus_rsp_valid.
  - Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with no bus_rsp_valid, pulse the owner's rsp_valid with rsp_err=1 and rsp_rdata=0, then go to IDLE.
  - If bus_rsp_valid arrives in the same cycle the timeout would fire, the bus response wins (err=0).
- bus_rsp_valid seen in IDLE or REQ is ignored (stale).
- Minimum latency, valid → rsp_valid with a zero-wait bus:
  - cycle 0: grant
  - cycle 1: bus_req_valid
  - cycle 2: bus_rsp_valid
  - cycle 3: rsp pulse, FSM back in IDLE
  - A new grant is possible in the same cycle as the rsp pulse.
- Reset:
  - State values: FSM=IDLE, owner=fetch, last_grant=data, counter=0.
  - Output values: all *_ready, *_rsp_valid, bus_req_valid, bus_wen and rsp_err are 0; bus_addr, bus_wdata and rsp_rdata are 0; bus_wstrb=0.
  - Reset asserted mid-transaction aborts it: no response is delivered, and the requester must re-request.
- Concurrency: at most one *_rsp_valid is high per cycle, and at most one *_req_ready is high per cycle.

Test Plan:
- Single fetch to 0x0000_1000, bus ready immediately, responds next cycle with 0xDEADBEEF → if_req_ready at cycle 0; if_rsp_valid at cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Fetch, data and PTW all valid in the same cycle, each held until accepted → grant order PTW, fetch, data. Repeating with only fetch and data continuously valid → strict alternation F,D,F,D.
- Store to 0x8000_0004, wdata=0x12345678, wstrb=4'b0011 → bus sees wen=1 and the exact payload; d_rsp_valid pulses once with err=0.
- bus_req_ready held low 5 cycles → bus_req_valid held with a stable payload; no other ready is asserted meanwhile.
- TIMEOUT_CYCLES=8, bus never responds → owner's rsp_valid pulses with rsp_err=1 and rsp_rdata=0; the next request is then served normally, and a stale bus_rsp_valid in IDLE produces no pulse.
- rst_n low during RSP → all outputs return to reset values; no rsp pulse appears after release.
